// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if
//   Core data-bus view of the UART transmitter register window.
//   master : the core side; drives address, strobes, byte enables and write data.
//   slave  : the UART side; returns combinational read data.
//   iAddress     [31:0] byte address
//   iWriteEnable        write strobe
//   iReadEnable         read strobe
//   iByteEnable  [3:0]  byte lanes of the access
//   iWriteData   [31:0] write data
//   oReadData    [31:0] read data, 0 when the window is not selected
interface uart_tx_mmio_if;
  logic [31:0] iAddress;
  logic        iWriteEnable;
  logic        iReadEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] iWriteData;
  logic [31:0] oReadData;

  modport master (
    output iAddress, iWriteEnable, iReadEnable, iByteEnable, iWriteData,
    input  oReadData
  );

  modport slave (
    input  iAddress, iWriteEnable, iReadEnable, iByteEnable, iWriteData,
    output oReadData
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
//   Memory-mapped 8N1 UART transmitter. Bytes written to DATA are queued in a
//   circular FIFO and shifted out LSB first on oTx, each bit lasting a
//   programmable number of iCLK cycles.
//   iCLK  : single clock
//   iRST  : synchronous active-high reset
//   bus   : core data-bus slave port (address, strobes, byte enables, data)
//   oTx   : registered serial line, idles high
//   oIrq  : registered level interrupt (irq_en & FIFO empty & transmitter idle)
//
//   Register window (16 bytes at BASE_ADDR):
//     0x0 DATA   W: push byte lane 0           R: 0
//     0x4 STATUS R: [0]busy [1]full [2]empty [3]overflow [12:8]count
//     0x8 DIV    RW: [15:0] bit period, writing 0 stores 1
//     0xC CTRL   RW: [0]enable [1]irq_en; W1 pulses [2]fifo_clear [3]ovf_clear
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | line high, waiting for enable & FIFO not empty
//   START  | driving the start bit (low) for cur_div cycles
//   DATA   | driving data bit bit_idx (0..7) for cur_div cycles each
//   STOP   | driving the stop bit (high); chains straight into START if more data
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'hFF20_0100,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic          iCLK,
  input  logic          iRST,
  uart_tx_mmio_if.slave bus,
  output logic          oTx,
  output logic          oIrq
);

  // FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap for free.
  localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ------------------------------------------------------------------
  // Bus decode
  // ------------------------------------------------------------------
  logic       sel;
  logic [1:0] reg_idx;
  logic       wr_en;
  logic       push_req;
  logic       div_wr;
  logic       ctrl_wr;
  logic       fifo_clr;
  logic       ovf_clr;

  assign sel      = (bus.iAddress[31:4] == BASE_ADDR[31:4]);
  assign reg_idx  = bus.iAddress[3:2];
  assign wr_en    = sel & bus.iWriteEnable;
  assign push_req = wr_en & (reg_idx == 2'd0) & bus.iByteEnable[0];
  assign div_wr   = wr_en & (reg_idx == 2'd2) & (|bus.iByteEnable[1:0]);
  assign ctrl_wr  = wr_en & (reg_idx == 2'd3) & bus.iByteEnable[0];
  assign fifo_clr = ctrl_wr & bus.iWriteData[2];
  assign ovf_clr  = ctrl_wr & bus.iWriteData[3];

  // Address bits [1:0], upper byte lanes and upper data bits are never decoded.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.iAddress[1:0], bus.iByteEnable[3:2],
                             bus.iWriteData[31:16]};

  // ------------------------------------------------------------------
  // Configuration registers
  // ------------------------------------------------------------------
  logic [15:0] div_q, div_d;
  logic        enable_q, enable_d;
  logic        irq_en_q, irq_en_d;

  always_comb begin
    div_d    = div_q;
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    if (div_wr) begin
      if (bus.iByteEnable[0]) div_d[7:0]  = bus.iWriteData[7:0];
      if (bus.iByteEnable[1]) div_d[15:8] = bus.iWriteData[15:8];
      // A zero-length bit would never reach terminal count.
      if (div_d == 16'd0) div_d = 16'd1;
    end
    if (ctrl_wr) begin
      enable_d = bus.iWriteData[0];
      irq_en_d = bus.iWriteData[1];
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      div_q    <= DEFAULT_DIV;
      enable_q <= 1'b1;
      irq_en_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
    end
  end

  // ------------------------------------------------------------------
  // TX FIFO
  // ------------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_ok;
  logic             pop;
  logic [7:0]       pop_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign pop_data   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (fifo_clr) begin
      // Clear beats a simultaneous push; overflow is left alone.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        count_d  = count_d + CNT_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = count_d - CNT_ONE;
      end
      if (push_req & ~push_ok) ovf_d = 1'b1;
    end
    if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (push_ok & ~fifo_clr) mem_q[wr_ptr_q] <= bus.iWriteData[7:0];
  end

  // ------------------------------------------------------------------
  // TX FSM
  // ------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] cur_div_q, cur_div_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        irq_q, irq_d;
  logic        bit_end;
  logic        start_ok;

  assign bit_end  = (baud_q == cur_div_q - 16'd1);
  // Decided from registered count only, so a byte pushed this cycle waits one edge.
  assign start_ok = enable_q & ~fifo_empty;

  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:  if (bit_end && bit_idx_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = start_ok ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    tx_d      = tx_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    cur_div_d = cur_div_q;
    unique case (state_q)
      S_IDLE: begin
        tx_d      = 1'b1;
        baud_d    = 16'd0;
        bit_idx_d = 3'd0;
        if (start_ok) begin
          pop       = 1'b1;
          shift_d   = pop_data;
          cur_div_d = div_q;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d    = 16'd0;
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = 16'd0;
          tx_d   = 1'b1;
          if (start_ok) begin
            pop       = 1'b1;
            shift_d   = pop_data;
            cur_div_d = div_q;
            tx_d      = 1'b0;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: ;
    endcase
    irq_d = irq_en_d & (count_d == '0) & (state_d == S_IDLE);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      baud_q    <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      cur_div_q <= DEFAULT_DIV;
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      cur_div_q <= cur_div_d;
      tx_q      <= tx_d;
      irq_q     <= irq_d;
    end
  end

  assign oTx  = tx_q;
  assign oIrq = irq_q;

  // ------------------------------------------------------------------
  // Read mux (combinational, no side effects)
  // ------------------------------------------------------------------
  logic [31:0] status;
  logic [31:0] rd_mux;

  always_comb begin
    status       = 32'd0;
    status[0]    = (state_q != S_IDLE);
    status[1]    = fifo_full;
    status[2]    = fifo_empty;
    status[3]    = ovf_q;
    status[12:8] = 5'(count_q);
    rd_mux       = 32'd0;
    unique case (reg_idx)
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = {16'd0, div_q};
      2'd3:    rd_mux = {30'd0, irq_en_q, enable_q};
      default: rd_mux = 32'd0;
    endcase
  end

  assign bus.oReadData = (sel & bus.iReadEnable) ? rd_mux : 32'd0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE   = 32'hFF20_0100;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_DIV  = BASE + 32'h8;
  localparam logic [31:0] A_CTRL = BASE + 32'hC;

  typedef struct {
    logic [7:0] b;
    int         div;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic irq;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_wr = 0;

  exp_t exp_q[$];
  int   start_q[$];
  int   frames_rx = 0;

  uart_tx_mmio_if bus();

  uart_tx_mmio #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (16),
    .DEFAULT_DIV(16'd434)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus),
    .oTx (tx),
    .oIrq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

  // Serial-line monitor: pops the expected byte/period at each start bit and
  // samples every bit in the middle of its period.
  initial begin : monitor
    bit         active;
    bit         have;
    exp_t       cur;
    int         t0, off, d, half, idx;
    logic [7:0] rx;
    active = 0;
    have = 0;
    t0 = 0;
    rx = 8'h00;
    cur.b = 8'h00;
    cur.div = 4;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        active = 0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1;
          t0 = cyc;
          start_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            have = 0;
            checks++;
            errors++;
            $display("FAIL frame_unexpected: start bit at cycle %0d, required no frame", cyc);
          end else begin
            cur = exp_q.pop_front();
            have = 1;
          end
        end
      end else begin
        off  = cyc - t0;
        d    = have ? cur.div : 4;
        half = d / 2;
        if (off == half) begin
          checks++;
          if (tx !== 1'b0) begin
            errors++;
            $display("FAIL start_bit: line=%b at mid start bit (cycle %0d), required 0", tx, cyc);
          end
        end else if (off >= d + half && off <= 8 * d + half && ((off - half) % d) == 0) begin
          idx = (off - half) / d - 1;
          rx[idx] = tx;
        end else if (off == 9 * d + half) begin
          checks++;
          if (tx !== 1'b1 || (have && rx !== cur.b)) begin
            errors++;
            $display("FAIL frame_data: got byte %h stop %b, required byte %h stop 1",
                     rx, tx, cur.b);
          end
          frames_rx++;
          active = 0;
        end
      end
    end
  end

  task automatic bus_idle();
    bus.iAddress     = 32'd0;
    bus.iWriteEnable = 1'b0;
    bus.iReadEnable  = 1'b0;
    bus.iByteEnable  = 4'h0;
    bus.iWriteData   = 32'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.iAddress     = a;
    bus.iWriteData   = d;
    bus.iByteEnable  = be;
    bus.iWriteEnable = 1'b1;
    bus.iReadEnable  = 1'b0;
    @(posedge clk);
    #1;
    last_wr = cyc;
    bus.iWriteEnable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.iAddress    = a;
    bus.iReadEnable = 1'b1;
    #1;
    d = bus.oReadData;
    bus.iReadEnable = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] st;
    int n;
    n = 0;
    st = 32'h1;
    while (st[0] !== 1'b0 && n < budget) begin
      rd(A_STAT, st);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", st[0], budget);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    bus_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rd(A_STAT, r);
    checks++;
    if (r !== 32'h0000_0004) begin errors++; $display("FAIL reset_status: got %h, required 00000004", r); end
    rd(A_DIV, r);
    checks++;
    if (r !== 32'd434) begin errors++; $display("FAIL reset_div: got %0d, required 434", r); end
    rd(A_CTRL, r);
    checks++;
    if (r !== 32'h1) begin errors++; $display("FAIL reset_ctrl: got %h, required 1", r); end
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b, required 0", irq); end
  endtask

  task automatic test_frame_55();
    logic [31:0] r;
    logic [7:0]  b;
    logic        etx, ebusy;
    int          n, k;
    exp_t        e;
    b = 8'h55;
    wr(A_DIV, 32'd4, 4'h3);
    rd(A_DIV, r);
    checks++;
    if (r !== 32'd4) begin errors++; $display("FAIL div_write: got %0d, required 4", r); end
    e.b = b;
    e.div = 4;
    exp_q.push_back(e);
    wr(A_DATA, {24'd0, b}, 4'h1);
    n = last_wr;
    k = 0;
    while (k < 41) begin
      rd(A_STAT, r);
      k = cyc - n;
      if (k >= 1 && k <= 40) begin
        if (k <= 4)       etx = 1'b0;
        else if (k <= 36) etx = b[(k - 5) / 4];
        else              etx = 1'b1;
        checks++;
        if (tx !== etx) begin
          errors++;
          $display("FAIL frame55_tx: cycle N+%0d line=%b, required %b", k, tx, etx);
        end
      end
      if (k >= 1) begin
        ebusy = (k <= 40);
        checks++;
        if (r[0] !== ebusy) begin
          errors++;
          $display("FAIL frame55_busy: cycle N+%0d busy=%b, required %b", k, r[0], ebusy);
        end
      end
    end
  endtask

  task automatic test_overflow_back_to_back();
    logic [31:0] r;
    exp_t        e;
    int          rx0, n;
    wr(A_CTRL, 32'h0, 4'h1);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) begin
        e.b = 8'hA0 + 8'(i);
        e.div = 4;
        exp_q.push_back(e);
      end
      wr(A_DATA, 32'hA0 + 32'(i), 4'h1);
    end
    rd(A_STAT, r);
    checks++;
    if (r !== 32'h0000_100A) begin errors++; $display("FAIL ovf_status: got %h, required 0000100a", r); end
    wr(A_CTRL, 32'h8, 4'h1);
    rd(A_STAT, r);
    checks++;
    if (r !== 32'h0000_1002) begin errors++; $display("FAIL ovf_clear: got %h, required 00001002", r); end
    rd(A_CTRL, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL ctrl_pulse_read: got %h, required 0", r); end
    start_q.delete();
    rx0 = frames_rx;
    // Enable, then push on the very edge of the first pop: full FIFO plus pop.
    wr(A_CTRL, 32'h1, 4'h1);
    e.b = 8'hEE;
    e.div = 4;
    exp_q.push_back(e);
    wr(A_DATA, 32'hEE, 4'h1);
    rd(A_STAT, r);
    checks++;
    if (r !== 32'h0000_1003) begin errors++; $display("FAIL full_push_pop: got %h, required 00001003", r); end
    n = 0;
    while (frames_rx - rx0 < 17 && n < 17 * 40 + 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frames_rx - rx0 != 17) begin
      errors++;
      $display("FAIL b2b_frames: got %0d frames, required 17", frames_rx - rx0);
    end
    checks++;
    if (start_q.size() != 17) begin
      errors++;
      $display("FAIL b2b_starts: got %0d start bits, required 17", start_q.size());
    end else begin
      for (int i = 1; i < 17; i++) begin
        checks++;
        if (start_q[i] - start_q[i-1] != 40) begin
          errors++;
          $display("FAIL b2b_spacing: frame %0d period %0d, required 40", i, start_q[i] - start_q[i-1]);
        end
      end
    end
    wait_idle(100);
  endtask

  task automatic test_div_change();
    logic [31:0] r;
    exp_t        e;
    int          t_end;
    start_q.delete();
    e.b = 8'h3C;
    e.div = 4;
    exp_q.push_back(e);
    wr(A_DATA, 32'h3C, 4'h1);
    e.b = 8'hC3;
    e.div = 8;
    exp_q.push_back(e);
    wr(A_DATA, 32'hC3, 4'h1);
    repeat (10) @(negedge clk);
    wr(A_DIV, 32'd8, 4'h3);
    rd(A_DIV, r);
    checks++;
    if (r !== 32'd8) begin errors++; $display("FAIL div_mid_frame: got %0d, required 8", r); end
    wait_idle(300);
    t_end = cyc;
    checks++;
    if (start_q.size() != 2) begin
      errors++;
      $display("FAIL divchg_starts: got %0d start bits, required 2", start_q.size());
    end else begin
      checks++;
      if (start_q[1] - start_q[0] != 40) begin
        errors++;
        $display("FAIL divchg_frame1: length %0d, required 40", start_q[1] - start_q[0]);
      end
      checks++;
      if (t_end - start_q[1] != 80) begin
        errors++;
        $display("FAIL divchg_frame2: length %0d, required 80", t_end - start_q[1]);
      end
    end
    wr(A_DIV, 32'd0, 4'h3);
    rd(A_DIV, r);
    checks++;
    if (r !== 32'd1) begin errors++; $display("FAIL div_zero: got %0d, required 1", r); end
    wr(A_DIV, 32'd4, 4'h3);
    wr(A_DIV, 32'h0000_1234, 4'h2);
    rd(A_DIV, r);
    checks++;
    if (r !== 32'h1204) begin errors++; $display("FAIL div_lane1: got %h, required 1204", r); end
    wr(A_DIV, 32'd4, 4'h3);
  endtask

  task automatic test_irq_reset();
    logic [31:0] r;
    exp_t        e;
    int          n, k;
    logic        eirq;
    wr(A_CTRL, 32'h3, 4'h1);
    rd(A_CTRL, r);
    checks++;
    if (r !== 32'h3) begin errors++; $display("FAIL ctrl_read: got %h, required 3", r); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_idle: got %b, required 1", irq); end
    e.b = 8'h81;
    e.div = 4;
    exp_q.push_back(e);
    wr(A_DATA, 32'h81, 4'h1);
    n = last_wr;
    k = 0;
    while (k < 41) begin
      @(negedge clk);
      k = cyc - n;
      eirq = (k >= 41);
      checks++;
      if (irq !== eirq) begin
        errors++;
        $display("FAIL irq_frame: cycle N+%0d irq=%b, required %b", k, irq, eirq);
      end
    end
    e.b = 8'h7E;
    e.div = 4;
    exp_q.push_back(e);
    wr(A_DATA, 32'h7E, 4'h1);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b, required 1", tx); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b, required 0", irq); end
    bus.iAddress = A_STAT;
    bus.iReadEnable = 1'b1;
    #1;
    r = bus.oReadData;
    bus.iReadEnable = 1'b0;
    checks++;
    if (r !== 32'h4) begin errors++; $display("FAIL rst_status: got %h, required 00000004", r); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_boundary();
    logic [31:0] r;
    rd(A_DIV, r);
    checks++;
    if (r !== 32'd434) begin errors++; $display("FAIL div_after_rst: got %0d, required 434", r); end
    wr(BASE + 32'h18, 32'd5, 4'hF);
    rd(A_DIV, r);
    checks++;
    if (r !== 32'd434) begin errors++; $display("FAIL oow_write: DIV %0d, required 434", r); end
    rd(BASE + 32'h18, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL oow_read: got %h, required 0", r); end
    wr(BASE + 32'h10, 32'h99, 4'h1);
    rd(A_STAT, r);
    checks++;
    if (r !== 32'h4) begin errors++; $display("FAIL oow_push: status %h, required 00000004", r); end
    @(negedge clk);
    bus.iAddress = A_STAT;
    bus.iReadEnable = 1'b0;
    #1;
    checks++;
    if (bus.oReadData !== 32'd0) begin
      errors++;
      $display("FAIL no_read_strobe: got %h, required 0", bus.oReadData);
    end
    wr(A_CTRL, 32'h0, 4'h1);
    for (int i = 0; i < 3; i++) wr(A_DATA, 32'h10 + 32'(i), 4'h1);
    rd(A_DATA, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL data_read: got %h, required 0", r); end
    rd(A_STAT, r);
    checks++;
    if (r !== 32'h0000_0300) begin errors++; $display("FAIL count3: status %h, required 00000300", r); end
    wr(A_CTRL, 32'h4, 4'h1);
    rd(A_STAT, r);
    checks++;
    if (r !== 32'h4) begin errors++; $display("FAIL fifo_clear: status %h, required 00000004", r); end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_frame_55();
    test_overflow_back_to_back();
    test_div_change();
    test_irq_reset();
    test_boundary();
    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d frames outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the CPU data bus, downstream of the processor core.
- Consumes the core's data-bus writes: address, write/read enables, byte enables and write data.
- Returns combinational read data to the core's read-data mux.
- Buffers bytes in a FIFO and serialises them 8N1, LSB first, on oTx at a programmable bit period.

Parameters:
- BASE_ADDR, 32'hFF20_0100: 16-byte aligned base of the register window.
- FIFO_DEPTH, 16: TX FIFO entries; must be a power of 2, minimum 2.
- DEFAULT_DIV, 16'd434: reset value of the bit-period divisor, in iCLK cycles.

Ports:
- iCLK  in  1  : single clock.
- iRST  in  1  : synchronous, active-high reset.
- iAddress  in  32  : byte address from the core data bus.
- iWriteEnable  in  1  : bus write strobe.
- iReadEnable  in  1  : bus read strobe.
- iByteEnable  in  4  : byte lanes of the access.
- iWriteData  in  32  : bus write data.
- oReadData  out  32  : combinational read data; 0 when the window is not selected.
- oTx  out  1  : serial line, registered; idles high.
- oIrq  out  1  : level interrupt, registered.

Behaviour:
- Select: sel = (iAddress[31:4] == BASE_ADDR[31:4]); iAddress[3:2] picks the register; iAddress[1:0] is ignored.
- Writes take effect at the rising edge when sel & iWriteEnable.
- Reads are side-effect free: oReadData = sel & iReadEnable ? reg : 0.
- 0x0 DATA:
  - Write with iByteEnable[0]=1 pushes iWriteData[7:0].
  - Reads return 0.
- 0x4 STATUS (read-only):
  - bit0 busy: FSM not IDLE.
  - bit1 full.
  - bit2 empty.
  - bit3 overflow, sticky.
  - bits[12:8] count.
  - All other bits 0.
- 0x8 DIV:
  - bits[15:0] divisor, lanes 0–1.
  - A write of 0 stores 1.
- 0xC CTRL:
  - bit0 enable, reset 1.
  - bit1 irq_en, reset 0.
  - bit2 fifo_clear: write-1 pulse, reads 0.
  - bit3 ovf_clear: write-1 pulse, reads 0.
- Reset (sync):
  - FIFO empty, count 0, overflow 0.
  - DIV = DEFAULT_DIV, CTRL = 0x1.
  - FSM IDLE, oTx=1, oIrq=0, bit/baud counters 0.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - count = 0..FIFO_DEPTH.
  - Push while full with no same-cycle pop: byte dropped, overflow set.
  - Push while full with same-cycle pop: accepted, count unchanged.
  - Push into empty: no same-cycle pop, because pop is decided from the registered count.
  - fifo_clear and push in the same cycle: clear wins, byte is lost, overflow unaffected.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: if enable & !empty, pop, latch byte into shift reg and DIV into cur_div, go to START; oTx=0 from that edge.
  - Each state bit lasts cur_div cycles, counted by baud_cnt 0..cur_div-1.
  - START -> DATA: oTx = shift[0]; bit_idx = 0.
  - DATA: at each bit end, shift right, increment bit_idx. After bit 7, go to STOP with oTx=1.
  - STOP end, enable & !empty: pop and go directly to START (no idle gap).
  - STOP end, otherwise: go to IDLE.
  - Frame = 10*cur_div cycles from the pop edge.
- Latency: push at edge N → pop and start bit at edge N+1 (if IDLE and enabled).
- DIV written mid-frame: ignored until the next frame latch.
- enable cleared mid-frame: the current frame completes; no new frame starts.
- fifo_clear mid-frame: the current frame completes.
- oIrq registered: irq_en & empty & (state==IDLE), evaluated on next-state values.
- Reset mid-frame: the line returns high the next cycle and the frame is abandoned.

Test Plan:
- Reset, then read STATUS → 0x0000_0004; read DIV → 434; oTx=1; oIrq=0.
- Write DIV=4, then DATA=0x55 at edge N:
  - oTx low for cycles N+1..N+4.
  - Then bits 1,0,1,0,1,0,1,0, 4 cycles each.
  - Stop bit high N+37..N+40; busy drops at N+41.
- With DIV=4 and enable=0, push 17 bytes:
  - count=16, full=1, overflow=1.
  - Write CTRL ovf_clear=1 → overflow=0.
  - Set enable=1 → 16 back-to-back frames of 40 cycles each, with no high gap between the stop bit and the next start bit.
- Frame in progress with DIV=4; write DIV=8 → current frame stays 40 cycles; next frame is 80 cycles. Write DIV=0 → read DIV returns 1.
- irq_en=1, push 1 byte → oIrq=0 during the frame, 1 after the stop bit ends. Assert iRST mid-frame → oTx=1 and STATUS=0x4 the next cycle.
- Boundary cases:
  - Read DATA → 0.
  - Access at BASE_ADDR+0x10 → no effect, oReadData=0.
  - Push when full with a simultaneous pop → accepted, overflow stays 0.
